// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and load-use hazard unit for a 5-stage MIPS pipeline.
//
// Each cycle the decoded operands and controls from ID are captured and shown
// to EX. The registered Rs/Rt/Rd and reg_write feed the EX forwarding unit.
//
// Three pieces of logic sit in front of the register:
//   - Load-use detection. If the instruction in EX is a load whose result the
//     ID instruction needs, o_stall holds PC and IF/ID for one cycle and a
//     bubble goes into EX.
//   - Branch flush. i_flush squashes the instruction entering EX. Flush has
//     priority over a stall.
//   - Write-first bypass. A value being written back this cycle replaces the
//     stale register-file read for Rs/Rt. Register 0 is never bypassed.
//
// A saturating counter records how many cycles were lost to load-use stalls.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_flush                   squash the instruction entering EX
//   i_IF_ID_*                 ID instruction: valid, Rs, Rt, Rd
//   i_uses_rt                 ID instruction reads Rt as an operand
//   i_rs_data / i_rt_data     register-file read data
//   i_imm, i_pc               extended immediate, PC+4
//   i_reg_write .. i_alu_op   decoder control bundle
//   i_MEM_WB_*                writeback enable / destination / value
//   o_stall                   combinational hold request to PC and IF/ID
//   o_ID_EX_*                 registered instruction presented to EX
//   o_stall_count             saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_IF_ID_valid,
   input  logic [4:0]        i_IF_ID_Rs,
   input  logic [4:0]        i_IF_ID_Rt,
   input  logic [4:0]        i_IF_ID_Rd,
   input  logic              i_uses_rt,
   input  logic [DATA_W-1:0] i_rs_data,
   input  logic [DATA_W-1:0] i_rt_data,
   input  logic [DATA_W-1:0] i_imm,
   input  logic [DATA_W-1:0] i_pc,
   input  logic              i_reg_write,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_mem_to_reg,
   input  logic              i_alu_src,
   input  logic [3:0]        i_alu_op,
   input  logic              i_MEM_WB_reg_write,
   input  logic [4:0]        i_MEM_WB_Rd,
   input  logic [DATA_W-1:0] i_MEM_WB_data,
   output logic              o_stall,
   output logic              o_ID_EX_valid,
   output logic [4:0]        o_ID_EX_Rs,
   output logic [4:0]        o_ID_EX_Rt,
   output logic [4:0]        o_ID_EX_Rd,
   output logic [DATA_W-1:0] o_ID_EX_rs_data,
   output logic [DATA_W-1:0] o_ID_EX_rt_data,
   output logic [DATA_W-1:0] o_ID_EX_imm,
   output logic [DATA_W-1:0] o_ID_EX_pc,
   output logic              o_ID_EX_reg_write,
   output logic              o_ID_EX_mem_read,
   output logic              o_ID_EX_mem_write,
   output logic              o_ID_EX_mem_to_reg,
   output logic              o_ID_EX_alu_src,
   output logic [3:0]        o_ID_EX_alu_op,
   output logic [CNT_W-1:0]  o_stall_count
);

   // Control fields. When these are all zero the EX stage treats the
   // instruction as a no-op.
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [3:0] alu_op;
   } ctrl_t;

   // Full ID/EX register contents. An all-zero value is a bubble.
   typedef struct packed {
      logic              valid;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      ctrl_t             ctrl;
   } id_ex_t;

   id_ex_t            id_ex_q;
   id_ex_t            id_ex_d;
   logic              hz;
   logic              rs_hit;
   logic              rt_hit;
   logic              wb_rs_hit;
   logic              wb_rt_hit;
   logic [DATA_W-1:0] rs_d;
   logic [DATA_W-1:0] rt_d;
   logic [CNT_W-1:0]  stall_count_q;

   // ---------------------------------------------------------------------------
   // Load-use hazard detection
   // ---------------------------------------------------------------------------
   // A load targeting $0 produces nothing to wait for, so it can never cause a
   // stall. A match on Rt only counts when the ID instruction actually reads
   // Rt as an operand. For example, sw uses Rt as store data and is handled by
   // forwarding later in the pipe.
   assign rs_hit = (id_ex_q.rd == i_IF_ID_Rs);
   assign rt_hit = i_uses_rt && (id_ex_q.rd == i_IF_ID_Rt);

   assign hz = id_ex_q.valid && id_ex_q.ctrl.mem_read && i_IF_ID_valid &&
               (id_ex_q.rd != 5'd0) && (rs_hit || rt_hit);

   // A taken branch squashes the dependent instruction anyway, so holding
   // IF/ID would only freeze the wrong-path fetch.
   assign o_stall = hz && !i_flush;

   // ---------------------------------------------------------------------------
   // MEM/WB write-first bypass into the operands read in ID
   // ---------------------------------------------------------------------------
   // The register file is written at the end of the cycle, so its read port
   // still returns the old value. Substitute the writeback value here so EX
   // does not need a third forwarding source.
   assign wb_rs_hit = i_MEM_WB_reg_write && (i_MEM_WB_Rd != 5'd0) &&
                      (i_MEM_WB_Rd == i_IF_ID_Rs);
   assign wb_rt_hit = i_MEM_WB_reg_write && (i_MEM_WB_Rd != 5'd0) &&
                      (i_MEM_WB_Rd == i_IF_ID_Rt);

   assign rs_d = wb_rs_hit ? i_MEM_WB_data : i_rs_data;
   assign rt_d = wb_rt_hit ? i_MEM_WB_data : i_rt_data;

   // ---------------------------------------------------------------------------
   // Next register value: flush > stall bubble > capture
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: the whole struct is defaulted before any branch so every path
      //       assigns every bit and no latch is inferred.
      id_ex_d = '0;
      if (!i_flush && !hz) begin
         id_ex_d.valid   = i_IF_ID_valid;
         id_ex_d.rs      = i_IF_ID_Rs;
         id_ex_d.rt      = i_IF_ID_Rt;
         id_ex_d.rd      = i_IF_ID_Rd;
         id_ex_d.rs_data = rs_d;
         id_ex_d.rt_data = rt_d;
         id_ex_d.imm     = i_imm;
         id_ex_d.pc      = i_pc;
         // A non-valid slot must not carry side effects into later stages.
         if (i_IF_ID_valid) begin
            id_ex_d.ctrl.reg_write  = i_reg_write;
            id_ex_d.ctrl.mem_read   = i_mem_read;
            id_ex_d.ctrl.mem_write  = i_mem_write;
            id_ex_d.ctrl.mem_to_reg = i_mem_to_reg;
            id_ex_d.ctrl.alu_src    = i_alu_src;
            id_ex_d.ctrl.alu_op     = i_alu_op;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pipeline register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      //       samples values from before the edge, whatever the block order.
      if (!i_rst_n) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall statistics: saturating, never wraps
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_count_q <= '0;
      end else if (o_stall && (stall_count_q != '1)) begin
         stall_count_q <= stall_count_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_ID_EX_valid      = id_ex_q.valid;
   assign o_ID_EX_Rs         = id_ex_q.rs;
   assign o_ID_EX_Rt         = id_ex_q.rt;
   assign o_ID_EX_Rd         = id_ex_q.rd;
   assign o_ID_EX_rs_data    = id_ex_q.rs_data;
   assign o_ID_EX_rt_data    = id_ex_q.rt_data;
   assign o_ID_EX_imm        = id_ex_q.imm;
   assign o_ID_EX_pc         = id_ex_q.pc;
   assign o_ID_EX_reg_write  = id_ex_q.ctrl.reg_write;
   assign o_ID_EX_mem_read   = id_ex_q.ctrl.mem_read;
   assign o_ID_EX_mem_write  = id_ex_q.ctrl.mem_write;
   assign o_ID_EX_mem_to_reg = id_ex_q.ctrl.mem_to_reg;
   assign o_ID_EX_alu_src    = id_ex_q.ctrl.alu_src;
   assign o_ID_EX_alu_op     = id_ex_q.ctrl.alu_op;
   assign o_stall_count      = stall_count_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard unit for the 5-stage MIPS pipeline.
- Captures decoded operands and controls from ID each cycle and presents them to EX.
- Its Rs/Rt/Rd and reg_write outputs feed the EX forwarding unit.
- Detects load-use hazards and stalls IF/ID with a bubble. Handles branch flush. Applies the MEM/WB write-first bypass to the operands read in ID.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- CNT_W, 16, width of the stall-statistics counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  branch/jump resolved taken in EX; squash the instruction entering EX.
- i_IF_ID_valid  input  1  the ID instruction is real (not a bubble).
- i_IF_ID_Rs  input  5  source register 1.
- i_IF_ID_Rt  input  5  source register 2.
- i_IF_ID_Rd  input  5  destination register, already muxed Rt/Rd/31.
- i_uses_rt  input  1  the ID instruction reads Rt as an operand.
- i_rs_data  input  DATA_W  register-file read data for Rs.
- i_rt_data  input  DATA_W  register-file read data for Rt.
- i_imm  input  DATA_W  extended immediate.
- i_pc  input  DATA_W  PC+4 of the ID instruction.
- i_reg_write  input  1  control bundle from the decoder.
- i_mem_read  input  1  control bundle from the decoder.
- i_mem_write  input  1  control bundle from the decoder.
- i_mem_to_reg  input  1  control bundle from the decoder.
- i_alu_src  input  1  control bundle from the decoder.
- i_alu_op  input  4  control bundle from the decoder.
- i_MEM_WB_reg_write  input  1  writeback enable.
- i_MEM_WB_Rd  input  5  writeback destination.
- i_MEM_WB_data  input  DATA_W  writeback value.
- o_stall  output  1  hold PC and IF/ID this cycle (combinational).
- o_ID_EX_valid  output  1  EX holds a real instruction.
- o_ID_EX_Rs  output  5  registered Rs.
- o_ID_EX_Rt  output  5  registered Rt.
- o_ID_EX_Rd  output  5  registered Rd.
- o_ID_EX_rs_data  output  DATA_W  registered operand.
- o_ID_EX_rt_data  output  DATA_W  registered operand.
- o_ID_EX_imm  output  DATA_W  registered immediate.
- o_ID_EX_pc  output  DATA_W  registered PC.
- o_ID_EX_reg_write  output  1  registered control.
- o_ID_EX_mem_read  output  1  registered control.
- o_ID_EX_mem_write  output  1  registered control.
- o_ID_EX_mem_to_reg  output  1  registered control.
- o_ID_EX_alu_src  output  1  registered control.
- o_ID_EX_alu_op  output  4  registered control.
- o_stall_count  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (i_rst_n low, asynchronous): every registered output goes to 0, o_stall_count goes to 0. o_stall is 0 while in reset.
- Hazard condition (combinational), "hz", is true when all of the following hold:
  - o_ID_EX_valid, o_ID_EX_mem_read, i_IF_ID_valid;
  - o_ID_EX_Rd != 0;
  - o_ID_EX_Rd == i_IF_ID_Rs, or (i_uses_rt and o_ID_EX_Rd == i_IF_ID_Rt).
- o_stall = hz and not i_flush.
- Bypass (combinational, feeds the register D inputs):
  - rs_d = i_MEM_WB_data if i_MEM_WB_reg_write, i_MEM_WB_Rd != 0, and i_MEM_WB_Rd == i_IF_ID_Rs; otherwise rs_d = i_rs_data.
  - rt_d is the same rule using Rt.
  - Register 0 is never bypassed.
- Register update, each rising edge, in priority order:
  1. i_flush: load a bubble. valid and all six control fields go to 0. Rs/Rt/Rd/data/imm/pc fields go to 0.
  2. hz (stall): load a bubble, same as flush. The ID instruction stays in IF/ID, held by the upstream stage via o_stall.
  3. Otherwise: capture all inputs, with rs_d/rt_d substituted for the data. o_ID_EX_valid = i_IF_ID_valid. Controls are also zeroed when i_IF_ID_valid = 0.
- Latency is one cycle from ID inputs to ID_EX outputs.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM, hz is false, and the dependent instruction advances; forwarding from MEM/WB supplies the value.
- Flush and hz in the same cycle: flush wins, o_stall = 0, no count increment.
- o_stall_count increments by 1 on each edge where o_stall = 1. It saturates at all-ones and does not wrap.
- A reset asserted mid-stall clears the pending bubble and the counter immediately. The first edge after deassertion behaves as a normal capture.

Test Plan:
- Reset: hold i_rst_n = 0 with random inputs, then release -> all outputs 0. First edge with valid add $3,$1,$2 -> o_ID_EX_Rs = 1, Rt = 2, Rd = 3, reg_write = 1, valid = 1.
- Load-use: lw $5 in EX (mem_read = 1, Rd = 5), ID add $6,$5,$7 -> o_stall = 1 for one cycle and EX receives a bubble (valid = 0, reg_write = 0). Next edge: add captured with Rs = 5, o_stall_count = 1.
- No false stall: lw $0 in EX with ID using $0 -> o_stall = 0. lw $5 in EX with ID sw using $5 only as Rt and i_uses_rt = 0 -> o_stall = 0.
- Flush priority: hz and i_flush together -> o_stall = 0, bubble loaded, o_stall_count unchanged.
- WB bypass: i_MEM_WB_Rd = 4, reg_write = 1, data = 0xDEADBEEF; ID Rs = 4 with stale i_rs_data = 0x1 -> o_ID_EX_rs_data = 0xDEADBEEF. Same with Rd = 0 -> stale value kept.
- Counter saturation: CNT_W = 2, four consecutive stall cycles -> count sequence 1, 2, 3, 3.
